// File: rtl/ram8_fifo_ctrl_pkg.sv
// Shared widths and the port-operation type for the ram8 queue controller.
// WORD_W and RAM8_ADDR_W match the data and address widths of the ram8 store.
package ram8_fifo_ctrl_pkg;

    localparam int WORD_W      = 16;
    localparam int RAM8_ADDR_W = 3;

    // ram8 has a single port, so each cycle it does at most one of these operations.
    // A bypass leaves the port idle and loads the output register straight from push_data.
    typedef enum logic [1:0] {
        OP_IDLE   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_REFILL = 2'd2,
        OP_BYPASS = 2'd3
    } port_op_t;

endpackage

// File: rtl/ram8_fifo_ctrl.sv
// Queue controller that turns the external 8-word ram8 store into a FIFO.
// It holds up to 8 words in the RAM plus 1 in a registered output stage.
module ram8_fifo_ctrl
    import ram8_fifo_ctrl_pkg::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int ADDR_W = RAM8_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);

    localparam logic [ADDR_W:0]   DEPTH   = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    logic     pop_fire;
    logic     slot_free;
    logic     ram_empty;
    logic     ram_full;
    port_op_t op;

    assign pop_fire  = out_valid & pop_ready;
    assign slot_free = ~out_valid | pop_fire;
    assign ram_empty = (ram_cnt == '0);
    assign ram_full  = (ram_cnt == DEPTH);

    // Refill takes priority so the output stage never starves while the RAM holds data.
    always_comb begin
        // NOTE: give every always_comb output a default first so no path infers a latch.
        op = OP_IDLE;
        if (!ram_empty && slot_free) begin
            op = OP_REFILL;
        end else if (push_valid && ram_empty && slot_free) begin
            op = OP_BYPASS;
        end else if (push_valid && !ram_full) begin
            op = OP_WRITE;
        end
    end

    assign push_ready = (op != OP_REFILL) && !ram_full;
    assign ram_addr   = (op == OP_REFILL) ? rd_ptr : wr_ptr;
    assign ram_in     = push_data;
    // Gated by rst_n so the RAM cannot be written while the controller is held in reset.
    assign ram_load   = rst_n && (op == OP_WRITE);

    // RAM bookkeeping: pointers wrap naturally at 2**ADDR_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
        end else begin
            case (op)
                OP_WRITE: begin
                    wr_ptr  <= wr_ptr + PTR_ONE;
                    ram_cnt <= ram_cnt + CNT_ONE;
                end
                OP_REFILL: begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    ram_cnt <= ram_cnt - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    // Output stage: loaded from the RAM on refill, directly from push_data on bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (op)
                OP_REFILL: begin
                    out_valid <= 1'b1;
                    out_data  <= ram_out;
                end
                OP_BYPASS: begin
                    out_valid <= 1'b1;
                    out_data  <= push_data;
                end
                default: begin
                    if (pop_fire) begin
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pop_valid = out_valid;
    assign pop_data  = out_data;
    assign count     = ram_cnt + {{ADDR_W{1'b0}}, out_valid};

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Self-checking bench for ram8_fifo_ctrl with a behavioural ram8 and a queue reference model.
// Directed scenarios first, then a randomized push/pop phase.
module tb_ram8_fifo_ctrl;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk;
    logic          rst_n;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_in;
    logic          ram_load;
    logic [DW-1:0] ram_out;

    // Behavioural ram8: combinational read, write on posedge when load is high.
    logic [DW-1:0] mem [8];
    assign ram_out = mem[ram_addr];
    always @(posedge clk) begin
        if (ram_load) mem[ram_addr] <= ram_in;
    end

    ram8_fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_data   (pop_data),
        .count      (count),
        .ram_addr   (ram_addr),
        .ram_in     (ram_in),
        .ram_load   (ram_load),
        .ram_out    (ram_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the whole FIFO contents, oldest first, plus the number of RAM writes since reset.
    logic [DW-1:0] model_q [$];
    int            wr_n;
    logic          last_acc;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive at negedge, compare #1 later, then advance the model.
    task automatic step(input logic pv, input logic [DW-1:0] pd, input logic pr, input string tag);
        int   sz;
        int   ram_words;
        logic fire;
        logic exp_ready;
        logic acc;
        logic exp_load;
        @(negedge clk);
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
        sz        = model_q.size();
        ram_words = (sz > 0) ? sz - 1 : 0;
        fire      = (sz > 0) && pr;
        // The RAM port is busy refilling whenever the head leaves and more words wait behind it.
        exp_ready = !((ram_words > 0) && fire) && (ram_words < 8);
        acc       = pv && exp_ready;
        // An accepted word skips the RAM only if the FIFO is otherwise empty this cycle.
        exp_load  = acc && ((sz - (fire ? 1 : 0)) != 0);

        check({tag, ".pop_valid"}, 32'(pop_valid), 32'(sz > 0));
        if (sz > 0) check({tag, ".pop_data"}, 32'(pop_data), 32'(model_q[0]));
        check({tag, ".count"}, 32'(count), 32'(sz));
        check({tag, ".push_ready"}, 32'(push_ready), 32'(exp_ready));
        check({tag, ".ram_load"}, 32'(ram_load), 32'(exp_load));
        check({tag, ".ram_in"}, 32'(ram_in), 32'(pd));
        if (exp_load) check({tag, ".ram_addr"}, 32'(ram_addr), 32'(wr_n % 8));

        if (fire) void'(model_q.pop_front());
        if (acc) model_q.push_back(pd);
        if (exp_load) wr_n++;
        last_acc = acc;
    endtask

    task automatic model_reset();
        model_q.delete();
        wr_n = 0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int pops;
        logic pr_t;

        model_reset();
        last_acc   = 1'b0;
        rst_n      = 1'b0;
        push_valid = 1'b1;
        push_data  = 16'h5555;
        pop_ready  = 1'b1;

        // 1: reset state, with push_valid high to show ram_load is held off
        #1;
        check("reset.pop_valid", 32'(pop_valid), 32'd0);
        check("reset.count", 32'(count), 32'd0);
        check("reset.ram_load", 32'(ram_load), 32'd0);
        check("reset.pop_data", 32'(pop_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n      = 1'b1;
        push_valid = 1'b0;
        #1;
        check("reset.push_ready", 32'(push_ready), 32'd1);

        // 2: single push into an empty FIFO bypasses the RAM
        step(1'b1, 16'h0001, 1'b0, "empty.push");
        step(1'b0, 16'h0000, 1'b0, "empty.hold");
        step(1'b0, 16'h0000, 1'b1, "empty.pop");
        step(1'b0, 16'h0000, 1'b0, "empty.after");

        // 3: fill to 9 words; the 10th is refused
        for (int i = 1; i <= 10; i++) step(1'b1, DW'(i), 1'b0, "fill");
        check("fill.count", 32'(count), 32'd9);
        check("fill.push_ready", 32'(push_ready), 32'd0);
        check("fill.tenth_refused", 32'(last_acc), 32'd0);
        step(1'b1, 16'h000A, 1'b0, "full.hold");

        // 4: drain in order, one word per cycle
        for (int i = 0; i < 11; i++) step(1'b0, 16'h0000, 1'b1, "drain");
        check("drain.pop_valid", 32'(pop_valid), 32'd0);
        check("drain.count", 32'(count), 32'd0);

        // 5: streaming with toggling consumer, RAM pointers wrap
        idx  = 0;
        pr_t = 1'b1;
        for (int c = 0; c < 200 && idx < 20; c++) begin
            step(1'b1, DW'(16'h0100 + idx), pr_t, "stream");
            if (last_acc) idx++;
            pr_t = ~pr_t;
        end
        check("stream.sent", 32'(idx), 32'd20);
        pops = 0;
        for (int c = 0; c < 40 && model_q.size() != 0; c++) begin
            step(1'b0, 16'h0000, 1'b1, "stream.flush");
            pops++;
        end
        check("stream.empty", 32'(model_q.size()), 32'd0);

        // 6: asynchronous reset in the middle of operation
        for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h0A00 + i), 1'b0, "midrst.fill");
        @(negedge clk);
        #1;
        check("midrst.count_before", 32'(count), 32'd5);
        push_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.pop_valid", 32'(pop_valid), 32'd0);
        check("midrst.count", 32'(count), 32'd0);
        check("midrst.ram_load", 32'(ram_load), 32'd0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n      = 1'b1;
        push_valid = 1'b0;
        step(1'b1, 16'hBEEF, 1'b0, "midrst.push");
        step(1'b1, 16'h1234, 1'b0, "midrst.first_write");
        step(1'b0, 16'h0000, 1'b1, "midrst.pop");
        check("midrst.beef_seen", 32'(last_acc), 32'd0);

        // Randomized phase against the queue model
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 2) == 0), "rand");
        end
        for (int c = 0; c < 12; c++) step(1'b0, 16'h0000, 1'b1, "rand.flush");
        check("rand.empty", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
